// File: rtl/bram_rd_unpacker.sv
// -----------------------------------------------------------------------------
// bram_rd_unpacker
//
// Read-side sequencer for an asymmetric simple-dual-port BRAM read port.
// A START_i pulse launches a burst of LEN_i word reads from BASE_ADDR_i. The
// address wraps modulo 2^ADDR_WIDTH. Each DATA_WIDTH word is split into RATIO
// OUT_WIDTH beats, least-significant slice first. The beats are presented on a
// valid/ready stream.
//
// Ports
//   clock0       in   rising-edge clock
//   RESET_ni     in   asynchronous active-low reset
//   START_i      in   1-cycle start pulse; only honoured while idle
//   BASE_ADDR_i  in   first word address, sampled with START_i
//   LEN_i        in   word count 0..2^ADDR_WIDTH, sampled with START_i
//   BUSY_o       out  burst in progress (RUN or FIN)
//   DONE_o       out  1-cycle pulse after the last beat is accepted
//   REN_o        out  BRAM read enable
//   RD_ADDR_o    out  BRAM read address
//   RDATA_i      in   BRAM read data, valid the cycle after REN_o
//   M_VALID_o    out  stream beat valid
//   M_DATA_o     out  stream beat data
//   M_LAST_o     out  final beat of the burst
//   M_READY_i    in   stream accept
// -----------------------------------------------------------------------------
module bram_rd_unpacker #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 18,  // must equal OUT_WIDTH*RATIO
    parameter int OUT_WIDTH  = 9,
    parameter int RATIO      = 2
) (
    input  logic                  clock0,
    input  logic                  RESET_ni,
    input  logic                  START_i,
    input  logic [ADDR_WIDTH-1:0] BASE_ADDR_i,
    input  logic [ADDR_WIDTH:0]   LEN_i,
    output logic                  BUSY_o,
    output logic                  DONE_o,
    output logic                  REN_o,
    output logic [ADDR_WIDTH-1:0] RD_ADDR_o,
    input  logic [DATA_WIDTH-1:0] RDATA_i,
    output logic                  M_VALID_o,
    output logic [OUT_WIDTH-1:0]  M_DATA_o,
    output logic                  M_LAST_o,
    input  logic                  M_READY_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam int SLW = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   issue_left;  // reads still to issue
    logic [ADDR_WIDTH:0]   pop_left;    // words still to emit; 1 means head is the last word
    logic                  in_flight;   // a read was issued last cycle, data arrives now
    logic [DATA_WIDTH-1:0] word_buf [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occ;         // buffered words, 0..2
    logic [SLW-1:0]        slice;

    logic                  ren;
    logic                  beat_valid;
    logic                  last_slice;
    logic                  xfer;
    logic                  pop;
    logic                  beat_last;
    logic [DATA_WIDTH-1:0] head;
    logic [OUT_WIDTH-1:0]  beat_data;

    // Reads in flight count against buffer space, so a captured word always
    // has a free entry and no read is ever dropped.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        beat_data  = '0;
        ren        = (state == S_RUN) && (issue_left != '0) && ((occ + {1'b0, in_flight}) < 2'd2);
        beat_valid = (state == S_RUN) && (occ != 2'd0);
        last_slice = (slice == SLW'(RATIO - 1));
        xfer       = beat_valid && M_READY_i;
        pop        = xfer && last_slice;
        beat_last  = beat_valid && last_slice && (pop_left == (ADDR_WIDTH+1)'(1));
        head       = word_buf[rd_ptr];
        if (beat_valid) begin
            for (int k = 0; k < RATIO; k++) begin
                if (slice == SLW'(k)) beat_data = head[k*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    always_ff @(posedge clock0 or negedge RESET_ni) begin
        if (!RESET_ni) begin
            state      <= S_IDLE;
            rd_addr    <= '0;
            issue_left <= '0;
            pop_left   <= '0;
            in_flight  <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            occ        <= 2'd0;
            slice      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (state)
                S_IDLE: begin
                    if (START_i) begin
                        rd_addr    <= BASE_ADDR_i;
                        issue_left <= LEN_i;
                        pop_left   <= LEN_i;
                        slice      <= '0;
                        state      <= (LEN_i == '0) ? S_FIN : S_RUN;
                    end
                end
                S_RUN:   if (xfer && beat_last) state <= S_FIN;
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            in_flight <= ren;
            if (ren) begin
                rd_addr    <= rd_addr + 1'b1;  // wraps modulo 2^ADDR_WIDTH
                issue_left <= issue_left - 1'b1;
            end

            if (xfer) slice <= last_slice ? '0 : slice + 1'b1;

            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                pop_left <= pop_left - 1'b1;
            end

            if (in_flight) wr_ptr <= ~wr_ptr;

            // A capture and a pop in the same cycle leave occupancy unchanged.
            case ({in_flight, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // NOTE: the word buffer has no reset; its contents are only observed
    // while occupancy says the entry holds a captured word.
    always_ff @(posedge clock0) begin
        if (in_flight) word_buf[wr_ptr] <= RDATA_i;
    end

    assign BUSY_o    = (state != S_IDLE);
    assign DONE_o    = (state == S_FIN);
    assign REN_o     = ren;
    assign RD_ADDR_o = rd_addr;
    assign M_VALID_o = beat_valid;
    assign M_DATA_o  = beat_data;
    assign M_LAST_o  = beat_last;

endmodule

// File: tb/tb_bram_rd_unpacker.sv
module tb_bram_rd_unpacker;

    localparam int AW = 10;
    localparam int DW = 18;
    localparam int OW = 9;
    localparam int R  = 2;

    logic          clock0 = 1'b0;
    logic          RESET_ni = 1'b0;
    logic          START_i = 1'b0;
    logic [AW-1:0] BASE_ADDR_i = '0;
    logic [AW:0]   LEN_i = '0;
    logic          BUSY_o, DONE_o, REN_o, M_VALID_o, M_LAST_o;
    logic [AW-1:0] RD_ADDR_o;
    logic [DW-1:0] RDATA_i = '0;
    logic [OW-1:0] M_DATA_o;
    logic          M_READY_i = 1'b0;

    bram_rd_unpacker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .RATIO(R)) dut (
        .clock0(clock0), .RESET_ni(RESET_ni), .START_i(START_i), .BASE_ADDR_i(BASE_ADDR_i),
        .LEN_i(LEN_i), .BUSY_o(BUSY_o), .DONE_o(DONE_o), .REN_o(REN_o), .RD_ADDR_o(RD_ADDR_o),
        .RDATA_i(RDATA_i), .M_VALID_o(M_VALID_o), .M_DATA_o(M_DATA_o), .M_LAST_o(M_LAST_o),
        .M_READY_i(M_READY_i)
    );

    always #5 clock0 = ~clock0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] bram_word(input int a);
        logic [8:0] i;
        i = a[8:0];
        return {i, ~i};
    endfunction

    // BRAM model: 1-cycle read latency, garbage when not reading.
    always @(posedge clock0) begin
        if (REN_o) RDATA_i <= bram_word(int'(RD_ADDR_o));
        else       RDATA_i <= DW'($urandom);
    end

    int cyc = 0;
    always @(posedge clock0) cyc++;

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    int            exp_addr_q[$];
    logic [OW-1:0] got_log[$];
    int            issued, beats_done, first_valid_cyc, last_beat_cyc, done_cnt, done_cyc;
    int            ready_mode = 0;
    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_data;
    logic          prev_last;
    beat_t         mon_b;

    // Ready driver: 0 = always high, 1 = toggle, 2 = random.
    initial begin
        forever begin
            @(posedge clock0);
            #1;
            case (ready_mode)
                0:       M_READY_i = 1'b1;
                1:       M_READY_i = ~M_READY_i;
                default: M_READY_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Compare process: all outputs sampled mid-cycle.
    always @(negedge clock0) begin
        if (!RESET_ni) begin
            prev_stall = 1'b0;
        end else begin
            if (REN_o) begin
                if (exp_addr_q.size() == 0) check("unexpected_ren", 1, 0);
                else check("rd_addr", RD_ADDR_o, exp_addr_q.pop_front());
                // words issued but not yet fully emitted (buffered + in flight)
                check("outstanding_lt2", 32'((issued - beats_done / R) < 2), 1);
                issued++;
            end
            if (M_VALID_o && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                check("stall_valid", M_VALID_o, 1);
                check("stall_data", M_DATA_o, prev_data);
                check("stall_last", M_LAST_o, prev_last);
            end
            if (M_VALID_o && M_READY_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    mon_b = exp_q.pop_front();
                    check("beat_data", M_DATA_o, mon_b.data);
                    check("beat_last", M_LAST_o, mon_b.last);
                end
                got_log.push_back(M_DATA_o);
                beats_done++;
                last_beat_cyc = cyc;
            end
            prev_stall = M_VALID_o && !M_READY_i;
            prev_data  = M_DATA_o;
            prev_last  = M_LAST_o;
            if (DONE_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic load_model(input int base, input int len);
        logic [DW-1:0] w;
        int a;
        for (int i = 0; i < len; i++) begin
            a = (base + i) % (1 << AW);
            exp_addr_q.push_back(a);
            w = bram_word(a);
            for (int k = 0; k < R; k++) begin
                exp_q.push_back('{data: w[k*OW +: OW], last: (i == len - 1) && (k == R - 1)});
            end
        end
        issued = 0; beats_done = 0; first_valid_cyc = -1; done_cnt = 0;
        got_log.delete();
    endtask

    task automatic pulse_start(input int base, input int len);
        @(posedge clock0); #1;
        START_i = 1'b1; BASE_ADDR_i = AW'(base); LEN_i = (AW+1)'(len);
        @(posedge clock0); #1;
        START_i = 1'b0; BASE_ADDR_i = AW'($urandom); LEN_i = (AW+1)'($urandom);
    endtask

    task automatic run_burst(input int base, input int len, input int mode, input bit mid_start);
        int start_cyc, t;
        ready_mode = mode;
        load_model(base, len);
        pulse_start(base, len);
        start_cyc = cyc - 1;
        check("busy_after_start", BUSY_o, 1);
        if (mid_start) begin
            repeat (3) @(posedge clock0);
            #1;
            START_i = 1'b1; BASE_ADDR_i = AW'(500); LEN_i = (AW+1)'(3);
            @(posedge clock0); #1;
            START_i = 1'b0;
        end
        t = 0;
        while (done_cnt == 0 && t < 500) begin
            @(posedge clock0);
            t++;
        end
        if (done_cnt == 0) check("done_timeout", 0, 1);
        @(posedge clock0); #1;
        check("busy_low_after_done", BUSY_o, 0);
        check("done_low_after_fin", DONE_o, 0);
        repeat (2) @(posedge clock0);
        #1;
        check("done_pulse_count", done_cnt, 1);
        check("beats_total", beats_done, len * R);
        check("reads_total", issued, len);
        check("model_beats_left", exp_q.size(), 0);
        check("model_addrs_left", exp_addr_q.size(), 0);
        if (mode == 0 && len > 0) begin
            check("first_valid_latency", first_valid_cyc - start_cyc, 3);
            check("no_bubbles", last_beat_cyc - first_valid_cyc, len * R - 1);
            check("done_after_last", done_cyc - last_beat_cyc, 1);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, BUSY_o, 0);
        check({tag, "_done"}, DONE_o, 0);
        check({tag, "_ren"}, REN_o, 0);
        check({tag, "_rd_addr"}, RD_ADDR_o, 0);
        check({tag, "_valid"}, M_VALID_o, 0);
        check({tag, "_data"}, M_DATA_o, 0);
        check({tag, "_last"}, M_LAST_o, 0);
    endtask

    logic [OW-1:0] t1_lit [8];
    int t;

    initial begin
        t1_lit = '{9'h1FF, 9'h000, 9'h1FE, 9'h001, 9'h1FD, 9'h002, 9'h1FC, 9'h003};

        // Reset state
        #1;
        check_idle_outputs("reset");
        repeat (3) @(posedge clock0);
        #1;
        RESET_ni = 1'b1;

        // 1: base 0, LEN 4, READY high; beats pinned to literal values
        run_burst(0, 4, 0, 1'b0);
        check("t1_count", got_log.size(), 8);
        for (int i = 0; i < 8 && i < got_log.size(); i++) check("t1_beat", got_log[i], t1_lit[i]);

        // 2: address wrap 1022,1023,0,1
        run_burst(1022, 4, 0, 1'b0);
        check("t2_count", got_log.size(), 8);
        if (got_log.size() == 8) begin
            check("t2_beat0", got_log[0], 9'h001);
            check("t2_beat1", got_log[1], 9'h1FE);
            check("t2_beat2", got_log[2], 9'h000);
            check("t2_beat4", got_log[4], 9'h1FF);
        end

        // 3: READY toggling; same beats as test 1
        run_burst(0, 4, 1, 1'b0);
        check("t3_count", got_log.size(), 8);
        for (int i = 0; i < 8 && i < got_log.size(); i++) check("t3_beat", got_log[i], t1_lit[i]);

        // 4: LEN 0
        run_burst(37, 0, 0, 1'b0);

        // 5: START re-pulsed mid-burst is ignored
        run_burst(100, 6, 2, 1'b1);

        // Randomised bursts
        for (int n = 0; n < 8; n++) begin
            run_burst($urandom_range(0, (1 << AW) - 1), $urandom_range(1, 20), 2, 1'b0);
        end
        run_burst(1020, 9, 1, 1'b0);

        // 6: reset after 3 beats, then a fresh 1-word burst
        ready_mode = 0;
        load_model(0, 4);
        pulse_start(0, 4);
        t = 0;
        while (beats_done < 3 && t < 100) begin
            @(posedge clock0);
            t++;
        end
        if (beats_done < 3) check("t6_beat_timeout", 0, 1);
        #1;
        RESET_ni = 1'b0;
        #1;
        check_idle_outputs("midreset");
        exp_q.delete();
        exp_addr_q.delete();
        done_cnt = 0;
        repeat (2) @(posedge clock0);
        #1;
        RESET_ni = 1'b1;
        repeat (3) @(posedge clock0);
        #1;
        check("t6_no_done", done_cnt, 0);
        check("t6_idle_busy", BUSY_o, 0);
        run_burst(0, 1, 0, 1'b0);
        check("t6_count", got_log.size(), 2);
        if (got_log.size() == 2) begin
            check("t6_beat0", got_log[0], 9'h1FF);
            check("t6_beat1", got_log[1], 9'h000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
